// File: rtl/axi_addr_arbiter.sv
// Round-robin arbiter sharing one AXI address channel between NUM_REQ show-ahead
// request FIFOs, tagging each command with the requester index and capping in-flight work.
module axi_addr_arbiter #(
  parameter int TAG_BITS = 2,
  parameter int NUM_REQ  = 2,
  parameter int IDX_W    = 1,
  parameter int MAX_OUT  = 2,
  localparam int ENTRY_W = 49 + TAG_BITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_empty,
  input  logic [NUM_REQ*ENTRY_W-1:0]   req_entry,
  output logic [NUM_REQ-1:0]           req_pop,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [ENTRY_W+IDX_W-1:0]     m_entry,
  input  logic                         done_valid,
  input  logic [IDX_W-1:0]             done_idx,
  output logic [NUM_REQ*3-1:0]         out_cnt,
  output logic                         err_underflow
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [0:0]                 state_q, state_d;
  logic                       m_valid_q, m_valid_d;
  logic [ENTRY_W+IDX_W-1:0]   m_entry_q, m_entry_d;
  logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0][2:0]    cnt_q, cnt_d;
  logic                       err_q, err_d;

  logic [NUM_REQ-1:0]         elig;
  logic [NUM_REQ-1:0]         pop;
  logic [NUM_REQ-1:0]         done_hit;
  logic [NUM_REQ-1:0]         cnt_zero;
  logic                       grant_vld;
  logic [IDX_W-1:0]           grant_idx;
  logic [ENTRY_W-1:0]         grant_entry;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] ptr, input int k);
    int s;
    s = int'(ptr) + k;
    return IDX_W'(s % NUM_REQ);
  endfunction

  // MAX_OUT <= 7 keeps the 3-bit count from wrapping on increment.
  function automatic logic [2:0] cnt_step(input logic [2:0] c, input logic inc, input logic dec);
    return c + {2'b00, inc} - {2'b00, dec};
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i]     = !req_empty[i] && (cnt_q[i] < 3'(MAX_OUT));
      done_hit[i] = done_valid && (done_idx == IDX_W'(i));
      cnt_zero[i] = (cnt_q[i] == 3'd0);
    end
  end

  // Scan starts just after the last winner, so it naturally ends up lowest priority.
  always_comb begin
    logic [IDX_W-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = wrap_idx(rr_ptr_q, k);
      if (!grant_vld && elig[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    grant_entry = '0;
    pop         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        grant_entry = req_entry[i*ENTRY_W +: ENTRY_W];
        pop[i]      = (state_q == IDLE) && grant_vld;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_step(cnt_q[i], pop[i], done_hit[i] && !cnt_zero[i]);
    end
    err_d = err_q | (done_valid && ((done_hit == '0) || ((done_hit & cnt_zero) != '0)));
  end

  always_comb begin
    state_d   = state_q;
    m_valid_d = m_valid_q;
    m_entry_d = m_entry_q;
    rr_ptr_d  = rr_ptr_q;
    if (state_q == IDLE) begin
      if (grant_vld) begin
        m_entry_d = {grant_idx, grant_entry};
        rr_ptr_d  = grant_idx;
        m_valid_d = 1'b1;
        state_d   = ISSUE;
      end
    end else if (m_ready) begin
      m_valid_d = 1'b0;
      state_d   = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      m_valid_q <= 1'b0;
      m_entry_q <= '0;
      rr_ptr_q  <= IDX_W'(NUM_REQ - 1);
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      m_entry_q <= m_entry_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // Pop is gated by reset so nothing is drained from the FIFOs while held in reset.
  assign req_pop       = pop & {NUM_REQ{rst}};
  assign m_valid       = m_valid_q;
  assign m_entry       = m_entry_q;
  assign out_cnt       = cnt_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_axi_addr_arbiter.sv
// Directed bench for axi_addr_arbiter with default parameters and a queue-based FIFO model.
module tb_axi_addr_arbiter;

  localparam int TAG_BITS = 2;
  localparam int NUM_REQ  = 2;
  localparam int IDX_W    = 1;
  localparam int MAX_OUT  = 2;
  localparam int ENTRY_W  = 49 + TAG_BITS;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NUM_REQ-1:0]         req_empty;
  logic [NUM_REQ*ENTRY_W-1:0] req_entry;
  logic [NUM_REQ-1:0]         req_pop;
  logic                       m_valid;
  logic                       m_ready;
  logic [ENTRY_W+IDX_W-1:0]   m_entry;
  logic                       done_valid;
  logic [IDX_W-1:0]           done_idx;
  logic [NUM_REQ*3-1:0]       out_cnt;
  logic                       err_underflow;

  logic [ENTRY_W-1:0] q0[$];
  logic [ENTRY_W-1:0] q1[$];
  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;

  axi_addr_arbiter #(
    .TAG_BITS(TAG_BITS), .NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst), .req_empty(req_empty), .req_entry(req_entry), .req_pop(req_pop),
    .m_valid(m_valid), .m_ready(m_ready), .m_entry(m_entry), .done_valid(done_valid),
    .done_idx(done_idx), .out_cnt(out_cnt), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [ENTRY_W-1:0] mk(input logic [1:0] id, input logic [31:0] addr);
    return {id, addr, 4'h3, 2'b10, 2'b01, 2'b00, 4'h3, 3'b010};
  endfunction

  task automatic refresh();
    req_empty[0] = (q0.size() == 0);
    req_empty[1] = (q1.size() == 0);
    req_entry[ENTRY_W-1:0]         = (q0.size() != 0) ? q0[0] : '0;
    req_entry[2*ENTRY_W-1:ENTRY_W] = (q1.size() != 0) ? q1[0] : '0;
    #1;
  endtask

  task automatic step();
    logic [NUM_REQ-1:0] p;
    logic hs;
    logic [ENTRY_W-1:0] tmp;
    p  = req_pop;
    hs = m_valid && m_ready && rst;
    @(posedge clk);
    #1;
    if (hs) hs_cnt++;
    if (p[0] && q0.size() > 0) tmp = q0.pop_front();
    if (p[1] && q1.size() > 0) tmp = q1.pop_front();
    refresh();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    q0.delete();
    q1.delete();
    m_ready = 1'b0;
    done_valid = 1'b0;
    done_idx = '0;
    refresh();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_ready = 1'b0; done_valid = 1'b0; done_idx = '0;
    q0.push_back(mk(2'b00, 32'h0000_0100));
    refresh();
    rst = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    checks++; if (req_pop !== 2'b00) begin errors++; $display("FAIL reset_req_pop got %b want 00", req_pop); end
    checks++; if (m_entry !== '0) begin errors++; $display("FAIL reset_m_entry got %h want 0", m_entry); end
    checks++; if (out_cnt !== 6'd0) begin errors++; $display("FAIL reset_out_cnt got %h want 0", out_cnt); end
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_underflow); end
  endtask

  task automatic test_single();
    logic [ENTRY_W-1:0] e;
    do_reset();
    e = mk(2'b01, 32'h1000_0040);
    m_ready = 1'b1;
    q0.push_back(e);
    refresh();
    checks++; if (req_pop !== 2'b01) begin errors++; $display("FAIL single_pop got %b want 01", req_pop); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_valid0 got %b want 0", m_valid); end
    step();
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_valid1 got %b want 1", m_valid); end
    checks++; if (m_entry !== {1'b0, e}) begin errors++; $display("FAIL single_entry got %h want %h", m_entry, {1'b0, e}); end
    checks++; if (out_cnt[2:0] !== 3'd1) begin errors++; $display("FAIL single_cnt got %0d want 1", out_cnt[2:0]); end
    checks++; if (req_pop !== 2'b00) begin errors++; $display("FAIL single_pop_issue got %b want 00", req_pop); end
    step();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_valid_after got %b want 0", m_valid); end
  endtask

  task automatic test_round_robin();
    logic [ENTRY_W+IDX_W-1:0] exp_e[4];
    int exp_c[4];
    int n;
    do_reset();
    exp_c = '{1, 3, 5, 7};
    q0.push_back(mk(2'b00, 32'hA000_0000));
    q0.push_back(mk(2'b01, 32'hA000_0010));
    q1.push_back(mk(2'b10, 32'hB000_0000));
    q1.push_back(mk(2'b11, 32'hB000_0010));
    exp_e[0] = {1'b0, mk(2'b00, 32'hA000_0000)};
    exp_e[1] = {1'b1, mk(2'b10, 32'hB000_0000)};
    exp_e[2] = {1'b0, mk(2'b01, 32'hA000_0010)};
    exp_e[3] = {1'b1, mk(2'b11, 32'hB000_0010)};
    m_ready = 1'b1;
    refresh();
    n = 0;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) step();
      if (m_valid === 1'b1 && n < 4) begin
        checks++; if (c != exp_c[n]) begin errors++; $display("FAIL rr_cycle%0d got %0d want %0d", n, c, exp_c[n]); end
        checks++; if (m_entry !== exp_e[n]) begin errors++; $display("FAIL rr_entry%0d got %h want %h", n, m_entry, exp_e[n]); end
        n++;
      end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL rr_count got %0d want 4", n); end
    checks++; if (out_cnt !== {3'd2, 3'd2}) begin errors++; $display("FAIL rr_out_cnt got %h want 12", out_cnt); end
  endtask

  task automatic test_max_out();
    logic [ENTRY_W-1:0] e2;
    int pops;
    do_reset();
    e2 = mk(2'b10, 32'hC000_0080);
    q0.push_back(mk(2'b00, 32'hC000_0000));
    q0.push_back(mk(2'b01, 32'hC000_0040));
    m_ready = 1'b1;
    refresh();
    pops = 0;
    for (int c = 0; c < 4; c++) begin
      if (req_pop === 2'b01) pops++;
      step();
    end
    checks++; if (pops != 2) begin errors++; $display("FAIL cap_first_pops got %0d want 2", pops); end
    q0.push_back(e2);
    refresh();
    for (int c = 0; c < 4; c++) begin
      checks++; if (req_pop !== 2'b00) begin errors++; $display("FAIL cap_blocked%0d got %b want 00", c, req_pop); end
      step();
    end
    done_valid = 1'b1; done_idx = 1'b0;
    #1;
    checks++; if (req_pop !== 2'b00) begin errors++; $display("FAIL cap_done_cycle got %b want 00", req_pop); end
    step();
    done_valid = 1'b0;
    #1;
    checks++; if (out_cnt[2:0] !== 3'd1) begin errors++; $display("FAIL cap_cnt_dec got %0d want 1", out_cnt[2:0]); end
    checks++; if (req_pop !== 2'b01) begin errors++; $display("FAIL cap_third_pop got %b want 01", req_pop); end
    step();
    checks++; if (m_entry !== {1'b0, e2}) begin errors++; $display("FAIL cap_third_entry got %h want %h", m_entry, {1'b0, e2}); end
    checks++; if (out_cnt[2:0] !== 3'd2) begin errors++; $display("FAIL cap_cnt_final got %0d want 2", out_cnt[2:0]); end
  endtask

  task automatic test_stall();
    logic [ENTRY_W-1:0] e;
    int hs0;
    do_reset();
    e = mk(2'b11, 32'hD000_0000);
    q0.push_back(e);
    q1.push_back(mk(2'b01, 32'hD100_0000));
    refresh();
    step();
    hs0 = hs_cnt;
    for (int c = 0; c < 5; c++) begin
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL stall_valid%0d got %b want 1", c, m_valid); end
      checks++; if (m_entry !== {1'b0, e}) begin errors++; $display("FAIL stall_entry%0d got %h want %h", c, m_entry, {1'b0, e}); end
      checks++; if (req_pop !== 2'b00) begin errors++; $display("FAIL stall_pop%0d got %b want 00", c, req_pop); end
      step();
    end
    m_ready = 1'b1;
    #1;
    step();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stall_release got %b want 0", m_valid); end
    checks++; if (hs_cnt - hs0 != 1) begin errors++; $display("FAIL stall_handshakes got %0d want 1", hs_cnt - hs0); end
    checks++; if (req_pop !== 2'b10) begin errors++; $display("FAIL stall_next_pop got %b want 10", req_pop); end
  endtask

  task automatic test_simul_underflow();
    do_reset();
    m_ready = 1'b1;
    q1.push_back(mk(2'b00, 32'hE000_0000));
    refresh();
    step();
    step();
    checks++; if (out_cnt[5:3] !== 3'd1) begin errors++; $display("FAIL simul_pre_cnt got %0d want 1", out_cnt[5:3]); end
    q1.push_back(mk(2'b01, 32'hE000_0040));
    refresh();
    done_valid = 1'b1; done_idx = 1'b1;
    #1;
    checks++; if (req_pop !== 2'b10) begin errors++; $display("FAIL simul_pop got %b want 10", req_pop); end
    step();
    done_valid = 1'b0;
    #1;
    checks++; if (out_cnt[5:3] !== 3'd1) begin errors++; $display("FAIL simul_cnt got %0d want 1", out_cnt[5:3]); end
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL simul_err got %b want 0", err_underflow); end
    done_valid = 1'b1; done_idx = 1'b0;
    step();
    done_valid = 1'b0;
    #1;
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uflow_err got %b want 1", err_underflow); end
    checks++; if (out_cnt[2:0] !== 3'd0) begin errors++; $display("FAIL uflow_cnt got %0d want 0", out_cnt[2:0]); end
    for (int c = 0; c < 3; c++) step();
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uflow_sticky got %b want 1", err_underflow); end
  endtask

  task automatic test_async_reset();
    do_reset();
    q0.push_back(mk(2'b01, 32'hF000_0000));
    q0.push_back(mk(2'b10, 32'hF000_0040));
    refresh();
    step();
    done_valid = 1'b1; done_idx = 1'b1;
    step();
    done_valid = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b1 || err_underflow !== 1'b1) begin errors++; $display("FAIL areset_setup got v=%b e=%b want v=1 e=1", m_valid, err_underflow); end
    rst = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b want 0", m_valid); end
    checks++; if (req_pop !== 2'b00) begin errors++; $display("FAIL areset_pop got %b want 00", req_pop); end
    checks++; if (out_cnt !== 6'd0) begin errors++; $display("FAIL areset_cnt got %h want 0", out_cnt); end
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL areset_err got %b want 0", err_underflow); end
    checks++; if (m_entry !== '0) begin errors++; $display("FAIL areset_entry got %h want 0", m_entry); end
    rst = 1'b1;
    #1;
    checks++; if (req_pop !== 2'b01) begin errors++; $display("FAIL areset_repop got %b want 01", req_pop); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_max_out();
    test_stall();
    test_simul_underflow();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
